// File: rtl/hazard_pkg.sv
// Shared types and constants for the five-stage pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } hz_state_t;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one Execute-stage operand; the Memory stage wins over Writeback.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] RsE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output fwd_t       fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (RegWriteM && (RdM != 5'd0) && (RdM == RsE)) begin
      fwd = FWD_MEM;
    end else if (RegWriteW && (RdW != 5'd0) && (RdW == RsE)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush,
// data-memory wait stall with a timeout watchdog, and a stall-cycle counter.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic        MemReqM,
  input  logic        MemReadyM,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic        MemFault,
  output logic [31:0] StallCount,
  output hz_state_t   dbg_state
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(MEM_TIMEOUT);

  hz_state_t     state;
  logic [CW-1:0] wait_cnt;
  fwd_t          fwd_a;
  fwd_t          fwd_b;
  logic          lw_stall;
  logic          mem_stall;

  fwd_sel u_fwd_a (
    .RsE       (Rs1E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .fwd       (fwd_a)
  );

  fwd_sel u_fwd_b (
    .RsE       (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .fwd       (fwd_b)
  );

  assign lw_stall  = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_stall = (MemReqM && !MemReadyM) || (state == FAULT);
  assign dbg_state = state;

  // A memory stall freezes the whole front end, so it also suppresses
  // D/E flushes; pending branch or load-use is re-evaluated on release.
  always_comb begin
    ForwardAE = fwd_a;
    ForwardBE = fwd_b;
    StallF    = mem_stall || lw_stall;
    StallD    = mem_stall || lw_stall;
    StallE    = mem_stall;
    StallM    = mem_stall;
    FlushD    = !mem_stall && PCSrcE;
    FlushE    = !mem_stall && (lw_stall || PCSrcE);
    FlushW    = mem_stall;
    if (reset) begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      wait_cnt   <= '0;
      StallCount <= '0;
      MemFault   <= 1'b0;
    end else begin
      StallCount <= StallCount + 32'(StallF);
      case (state)
        RUN: begin
          if (MemReqM && !MemReadyM) begin
            state    <= WAIT;
            wait_cnt <= CW'(1);
          end
        end
        WAIT: begin
          // A dropped request without ready is a protocol slip; just resume.
          if (MemReadyM || !MemReqM) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == TIMEOUT_CNT) begin
            state    <= FAULT;
            MemFault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        FAULT: begin
          MemFault <= 1'b1;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios plus random traffic, scored
// against a cycle-level reference model through an expected-value queue.
module tb_hazard_unit;
  import hazard_pkg::*;

  localparam int TO = 4;
  localparam int W  = 46;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE, MemReqM, MemReadyM;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, StallE, StallM;
  logic        FlushD, FlushE, FlushW;
  logic        MemFault;
  logic [31:0] StallCount;
  hz_state_t   dbg_state;

  // Handshake: one expected vector is pushed per driven cycle; the monitor
  // consumes one per falling edge, so every cycle is compared exactly once.
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_fault;
  int          m_run;
  logic [31:0] m_cnt;
  bit          m_stallf;

  hazard_unit #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemReqM(MemReqM),
    .MemReadyM(MemReadyM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemFault(MemFault), .StallCount(StallCount), .dbg_state(dbg_state)
  );

  // Clock/reset
  always #5 clk = ~clk;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Expected outputs for the inputs currently driven.
  function automatic logic [W-1:0] ref_out();
    bit mem, lw;
    logic [1:0] fa, fb, st;
    logic [3:0] stalls;
    logic [2:0] flushes;
    mem = m_fault || (MemReqM && !MemReadyM);
    lw  = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    fa  = ref_fwd(Rs1E);
    fb  = ref_fwd(Rs2E);
    stalls  = {mem || lw, mem || lw, mem, mem};
    flushes = {!mem && PCSrcE, !mem && (lw || PCSrcE), mem};
    if (reset) begin
      fa = 2'b00; fb = 2'b00; stalls = 4'b0000; flushes = 3'b111;
    end
    m_stallf = stalls[3];
    st = m_fault ? 2'd2 : (m_run > 0 ? 2'd1 : 2'd0);
    return {st, m_fault, m_cnt, fa, fb, stalls, flushes};
  endfunction

  // Driver: push expectation, let the edge happen, advance the model.
  task automatic tick();
    exp_q.push_back(ref_out());
    @(posedge clk);
    if (reset) begin
      m_fault = 0; m_run = 0; m_cnt = '0;
    end else begin
      m_cnt = m_cnt + 32'(m_stallf);
      if (!m_fault) begin
        if (MemReqM && !MemReadyM) begin
          m_run++;
          if (m_run > TO) m_fault = 1;
        end else begin
          m_run = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
    MemReqM = 0; MemReadyM = 1;
  endtask

  task automatic rand_inputs(input int ready_low_pct, input int req_pct);
    Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
    Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
    RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
    RdW  = 5'($urandom_range(0, 3));
    RegWriteM  = 1'($urandom_range(0, 1));
    RegWriteW  = 1'($urandom_range(0, 1));
    ResultSrcE = 2'($urandom_range(0, 3));
    PCSrcE     = ($urandom_range(0, 3) == 0);
    MemReqM    = ($urandom_range(0, 99) < req_pct);
    MemReadyM  = ($urandom_range(0, 99) >= ready_low_pct);
    reset      = ($urandom_range(0, 59) == 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] exp_v, act_v;
      exp_v = exp_q.pop_front();
      act_v = {dbg_state, MemFault, StallCount, ForwardAE, ForwardBE,
               StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t: actual st=%0d flt=%b cnt=%0d fa=%b fb=%b stall=%b flush=%b, expected st=%0d flt=%b cnt=%0d fa=%b fb=%b stall=%b flush=%b",
                 $time, act_v[45:44], act_v[43], act_v[42:11], act_v[10:9], act_v[8:7], act_v[6:3], act_v[2:0],
                 exp_v[45:44], exp_v[43], exp_v[42:11], exp_v[10:9], exp_v[8:7], exp_v[6:3], exp_v[2:0]);
      end
    end
  end

  initial begin
    idle_inputs();
    reset = 1;
    m_fault = 0; m_run = 0; m_cnt = '0; m_stallf = 0;
    @(posedge clk); #1;
    tick();                 // reset state
    reset = 0;
    tick();

    // Forwarding priority
    Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; tick();
    RdM = 0; tick();
    RdM = 5; Rs1E = 0; Rs2E = 5; tick();
    idle_inputs(); tick();

    // Load-use, single bubble then forward from W
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; tick();
    idle_inputs(); RdW = 7; RegWriteW = 1; Rs2E = 7; tick();
    idle_inputs();

    // Branch alone, then branch masked by a memory stall
    PCSrcE = 1; tick();
    MemReqM = 1; MemReadyM = 0; tick();
    MemReadyM = 1; tick();
    idle_inputs(); tick();

    // Three wait states then ready
    MemReqM = 1; MemReadyM = 0;
    repeat (3) tick();
    MemReadyM = 1; tick();
    idle_inputs(); tick();

    // Simultaneous branch and load-use
    PCSrcE = 1; ResultSrcE = 2'b01; RdE = 3; Rs1D = 3; tick();
    idle_inputs();

    // Timeout into fault, then held, then reset recovery
    MemReqM = 1; MemReadyM = 0;
    repeat (8) tick();
    idle_inputs(); repeat (2) tick();
    reset = 1; tick();
    reset = 0; tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs(30, 40);
      tick();
    end
    for (int i = 0; i < 300; i++) begin
      rand_inputs(75, 95);
      tick();
    end
    idle_inputs(); tick();

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
